muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit that sits directly downstream of the register file.
- Consumes the two register-file read ports (rs value, rt value) and holds the MIPS HI/LO result pair.
- Execute stage must stall on busy; a later MFHI/MFLO reads hi/lo and writes the value back through the register-file write port.
- Multi-cycle: one radix-2 iteration per clock.

Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH; must be even and >= 4.

Ports:
- clock  input  1  single design clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when busy=0.
- op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved (no-op).
- operand_a  input  DATA_WIDTH  rs value (register-file read port A): multiplicand / dividend / MTxx source.
- operand_b  input  DATA_WIDTH  rt value (register-file read port B): multiplier / divisor.
- busy  output  1  high while an iterative operation is in progress.
- done  output  1  one-cycle pulse when hi/lo have been updated (or divide-by-zero reported).
- div_by_zero  output  1  pulses together with done when a DIV/DIVU has divisor 0.
- hi  output  DATA_WIDTH  HI register (product upper half / remainder).
- lo  output  DATA_WIDTH  LO register (product lower half / quotient).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. On reset: hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE.
- Reset mid-operation aborts the operation; hi/lo are zeroed and no done pulse is produced.
- States: IDLE, MUL, DIV, FIX.
- IDLE + start + MULT/MULTU (sampled at edge N):
  - Latch operand magnitudes (signed ops: take absolute value and record the result sign).
  - Go to MUL; busy=1 after edge N.
- IDLE + start + DIV/DIVU with operand_b!=0: same latching, go to DIV.
- IDLE + start + DIV/DIVU with operand_b==0:
  - Stay in IDLE; hi/lo unchanged.
  - done=1 and div_by_zero=1 for the cycle after edge N.
  - busy never rises.
- IDLE + start + MTHI/MTLO:
  - hi (resp. lo) := operand_a at edge N; the other register is unchanged.
  - done=1 for the cycle after edge N; busy stays 0.
- Reserved op: ignored; no done pulse.
- MUL: shift-add, one multiplier bit per cycle, 64-bit accumulator; DATA_WIDTH iterations on edges N+1..N+32, then FIX.
- DIV: restoring division, one quotient bit per cycle, DATA_WIDTH iterations, then FIX.
- FIX (edge N+33):
  - Apply sign correction and write hi/lo.
  - done=1 and busy=0 after this edge; return to IDLE.
  - Total latency: start to result visible = 33 edges.
- Signed multiply: hi:lo is the full 64-bit two's-complement product.
- Signed divide:
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - -2^31 / -1 gives lo=0x80000000, hi=0 (no trap).
- Unsigned ops treat operands as magnitudes with no correction.
- start while busy=1 is ignored (not queued). Operands are latched at acceptance, so later changes on operand_a/b have no effect.
- A new start may be accepted in the same cycle that done=1, since state is already IDLE.
- hi/lo hold their values indefinitely between operations; they are never partially updated during iteration (the working registers are separate).
- done and div_by_zero are single-cycle pulses, deasserted on the following edge unless a new single-cycle op completes.

Test Plan:
- Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy for 33 cycles; then hi=0xFFFFFFFE, lo=0x00000001, one done pulse.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). MULTU on the same operands -> hi=0x00000006, lo=0xFFFFFFEB.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100 b=7 -> lo=14, hi=2. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- After the previous result, DIVU a=5 b=0 -> done and div_by_zero for 1 cycle on the next cycle; busy stays 0; hi/lo unchanged.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 -> each done after 1 edge; hi=0x12345678, lo=0x9ABCDEF0. Then start MULT with operands changed mid-op and a second start pulsed while busy -> result matches the operands latched at acceptance; exactly one done pulse.
- Start MULT, assert reset at iteration 10 -> the following cycle shows busy=0, hi=lo=0; no done pulse; a fresh MULTU 3*5 then gives lo=15, hi=0 after 33 cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative MIPS-style multiply/divide unit holding the HI/LO result pair.
//   One radix-2 iteration per clock: shift-add multiply and restoring divide,
//   each taking DATA_WIDTH iterations followed by one sign-fix cycle. MTHI/MTLO
//   write HI/LO directly in a single cycle. A divide with a zero divisor is
//   reported immediately and leaves HI/LO untouched.
//
// Ports
//   clock        : design clock, all state changes on the rising edge
//   reset        : synchronous active-high reset
//   start        : request a new operation (only sampled while busy is low)
//   op           : 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//                  110/111 reserved (ignored)
//   operand_a    : rs value - multiplicand / dividend / MTHI-MTLO source
//   operand_b    : rt value - multiplier / divisor
//   busy         : an iterative operation is in progress
//   done         : one-cycle pulse when HI/LO were updated or div-by-zero seen
//   div_by_zero  : pulses with done when a divide had a zero divisor
//   hi, lo       : HI/LO architectural registers
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [W-1:0]   ONE_W    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0] ONE_2W   = {{(2*W-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    // Two's-complement negation helpers
    function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
        return ~v + ONE_W;
    endfunction

    function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v);
        return ~v + ONE_2W;
    endfunction

    // Magnitude of an operand; unsigned ops pass the value through untouched
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v,
                                               input logic      is_signed);
        logic [W-1:0] r;
        if (is_signed && v[W-1]) begin
            r = neg_w(v);
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    // Multiply: {partial product high, multiplier shifting out low}.
    // Divide:   {partial remainder, dividend shifting into quotient}.
    logic [2*W-1:0]  work_q, work_d;
    // Multiplicand magnitude or divisor magnitude
    logic [W-1:0]    opnd_q, opnd_d;
    logic            neg_lo_q, neg_lo_d;   // negate product / quotient
    logic            neg_hi_q, neg_hi_d;   // negate remainder
    logic            fix_div_q, fix_div_d; // FIX finishes a divide
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;

    logic [W:0]      mul_sum_s;
    logic [2*W-1:0]  mul_next_s;
    logic [W:0]      div_shift_s;
    logic [W:0]      div_diff_s;
    logic [2*W-1:0]  div_next_s;
    logic [2*W-1:0]  prod_fix_s;
    logic [W-1:0]    quo_fix_s;
    logic [W-1:0]    rem_fix_s;
    logic            is_signed_s;
    logic [W-1:0]    a_mag_s;
    logic [W-1:0]    b_mag_s;

    // Datapath for one iteration step and for the final sign correction
    always_comb begin
        // Shift-add: add multiplicand when the current multiplier bit is set,
        // then shift the whole accumulator right by one.
        if (work_q[0]) begin
            mul_sum_s = {1'b0, work_q[2*W-1:W]} + {1'b0, opnd_q};
        end else begin
            mul_sum_s = {1'b0, work_q[2*W-1:W]};
        end
        mul_next_s = {mul_sum_s, work_q[W-1:1]};

        // Restoring divide: bring in the next dividend bit, trial-subtract,
        // keep the difference only when it did not borrow.
        div_shift_s = work_q[2*W-1:W-1];
        div_diff_s  = div_shift_s - {1'b0, opnd_q};
        if (!div_diff_s[W]) begin
            div_next_s = {div_diff_s[W-1:0], work_q[W-2:0], 1'b1};
        end else begin
            div_next_s = {div_shift_s[W-1:0], work_q[W-2:0], 1'b0};
        end

        if (neg_lo_q) begin
            prod_fix_s = neg_2w(work_q);
            quo_fix_s  = neg_w(work_q[W-1:0]);
        end else begin
            prod_fix_s = work_q;
            quo_fix_s  = work_q[W-1:0];
        end

        if (neg_hi_q) begin
            rem_fix_s = neg_w(work_q[2*W-1:W]);
        end else begin
            rem_fix_s = work_q[2*W-1:W];
        end

        is_signed_s = (op == OP_MULT) || (op == OP_DIV);
        a_mag_s     = magnitude(operand_a, is_signed_s);
        b_mag_s     = magnitude(operand_b, is_signed_s);
    end

    // Next-state and register-update logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        opnd_d    = opnd_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        fix_div_d = fix_div_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            work_d    = {{W{1'b0}}, b_mag_s};
                            opnd_d    = a_mag_s;
                            neg_lo_d  = is_signed_s & (operand_a[W-1] ^ operand_b[W-1]);
                            neg_hi_d  = 1'b0;
                            fix_div_d = 1'b0;
                            cnt_d     = {CW{1'b0}};
                            state_d   = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (operand_b == {W{1'b0}}) begin
                                done_d = 1'b1;
                                dbz_d  = 1'b1;
                            end else begin
                                work_d    = {{W{1'b0}}, a_mag_s};
                                opnd_d    = b_mag_s;
                                // Quotient truncates toward zero; remainder
                                // follows the dividend's sign.
                                neg_lo_d  = is_signed_s & (operand_a[W-1] ^ operand_b[W-1]);
                                neg_hi_d  = is_signed_s & operand_a[W-1];
                                fix_div_d = 1'b1;
                                cnt_d     = {CW{1'b0}};
                                state_d   = S_DIV;
                            end
                        end
                        OP_MTHI: begin
                            hi_d   = operand_a;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = operand_a;
                            done_d = 1'b1;
                        end
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                work_d = mul_next_s;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_DIV: begin
                work_d = div_next_s;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_FIX: begin
                if (fix_div_q) begin
                    hi_d = rem_fix_s;
                    lo_d = quo_fix_s;
                end else begin
                    hi_d = prod_fix_s[2*W-1:W];
                    lo_d = prod_fix_s[W-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CW{1'b0}};
            work_q    <= {(2*W){1'b0}};
            opnd_q    <= {W{1'b0}};
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            fix_div_q <= 1'b0;
            hi_q      <= {W{1'b0}};
            lo_q      <= {W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            opnd_q    <= opnd_d;
            neg_lo_q  <= neg_lo_d;
            neg_hi_q  <= neg_hi_d;
            fix_div_q <= fix_div_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed bench for muldiv_unit: hand-computed multiply/divide results,
//   33-edge latency, divide-by-zero, MTHI/MTLO, reserved op, busy-start
//   rejection with mid-operation operand changes, and reset mid-operation.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_assert;
    int n_fail;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    // 10 ns clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present a request before edge N, leave the bench 1 ns after edge N
    task automatic issue(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clock);
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Iterative op: busy right after acceptance, done exactly 33 edges later
    task automatic run_iter(input string tag, input logic [2:0] o,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        issue(o, a, b);
        check({tag, "_busy_rise"}, {63'd0, busy}, 64'd1);
        cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            cyc = k;
            if (done) break;
        end
        check({tag, "_latency"}, 64'(cyc), 64'd33);
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
        check({tag, "_busy_fall"}, {63'd0, busy}, 64'd0);
        @(posedge clock);
        #1;
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int dones;
        n_assert  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        op        = 3'b000;
        operand_a = 32'd0;
        operand_b = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_hi",   {32'd0, hi}, 64'd0);
        check("rst_lo",   {32'd0, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_dbz",  {63'd0, div_by_zero}, 64'd0);
        reset = 1'b0;

        // Multiply
        run_iter("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_iter("mult_neg",  3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_iter("multu_neg", 3'b001, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB);

        // Divide
        run_iter("div_neg",   3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_iter("divu",      3'b011, 32'd100, 32'd7, 32'd2, 32'd14);
        run_iter("div_ovf",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // Divide by zero: immediate report, HI/LO unchanged, never busy
        issue(3'b011, 32'd5, 32'd0);
        check("dbz_done", {63'd0, done}, 64'd1);
        check("dbz_flag", {63'd0, div_by_zero}, 64'd1);
        check("dbz_busy", {63'd0, busy}, 64'd0);
        check("dbz_hi",   {32'd0, hi}, 64'd0);
        check("dbz_lo",   {32'd0, lo}, 64'h8000_0000);
        @(posedge clock);
        #1;
        check("dbz_done_fall", {63'd0, done}, 64'd0);
        check("dbz_flag_fall", {63'd0, div_by_zero}, 64'd0);
        check("dbz_busy_hold", {63'd0, busy}, 64'd0);

        // MTHI / MTLO
        issue(3'b100, 32'h1234_5678, 32'd0);
        check("mthi_done", {63'd0, done}, 64'd1);
        check("mthi_busy", {63'd0, busy}, 64'd0);
        check("mthi_hi",   {32'd0, hi}, 64'h1234_5678);
        check("mthi_lo",   {32'd0, lo}, 64'h8000_0000);
        issue(3'b101, 32'h9ABC_DEF0, 32'd0);
        check("mtlo_done", {63'd0, done}, 64'd1);
        check("mtlo_hi",   {32'd0, hi}, 64'h1234_5678);
        check("mtlo_lo",   {32'd0, lo}, 64'h9ABC_DEF0);

        // Reserved op: nothing happens
        issue(3'b110, 32'hDEAD_BEEF, 32'd1);
        check("rsv_done", {63'd0, done}, 64'd0);
        check("rsv_busy", {63'd0, busy}, 64'd0);
        check("rsv_hi",   {32'd0, hi}, 64'h1234_5678);
        check("rsv_lo",   {32'd0, lo}, 64'h9ABC_DEF0);

        // MULT -2 * 16 with operands changed and a rejected start while busy
        issue(3'b000, 32'hFFFF_FFFE, 32'h0000_0010);
        repeat (4) @(negedge clock);
        operand_a = 32'd5;
        operand_b = 32'd5;
        op        = 3'b100;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (done) dones++;
        end
        check("busy_start_dones", 64'(dones), 64'd1);
        check("busy_start_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        check("busy_start_lo", {32'd0, lo}, 64'hFFFF_FFE0);

        // Reset at iteration 10 aborts the multiply
        issue(3'b000, 32'd7, 32'd9);
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hi",   {32'd0, hi}, 64'd0);
        check("abort_lo",   {32'd0, lo}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        run_iter("multu_after_abort", 3'b001, 32'd3, 32'd5, 32'd0, 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
